// File: rtl/pe_control_seq.sv
// PE control sequencer: decodes 64-bit PE instructions into per-lane DSP48
// configuration, repeats each for rpt+1 cycles and drives the PE output mux.
module pe_control_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter int INST_WIDTH    = 64,
  parameter int NUM_DSP       = 4,
  parameter int ALUMODE_WIDTH = 4,
  parameter int INMODE_WIDTH  = 5,
  parameter int OPMODE_WIDTH  = 7,
  parameter int DELAY         = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH*2-1:0]           din_ld,
  input  logic [DATA_WIDTH*2-1:0]           din_pe,
  input  logic [DATA_WIDTH*2-1:0]           din_wb,
  input  logic                              inst_v,
  input  logic [INST_WIDTH-1:0]             inst,
  output logic                              inst_ready,
  output logic                              busy,
  output logic                              dout_v,
  output logic [DATA_WIDTH*2-1:0]           dout,
  output logic [ALUMODE_WIDTH*NUM_DSP-1:0]  alumode,
  output logic [INMODE_WIDTH*NUM_DSP-1:0]   inmode,
  output logic [OPMODE_WIDTH*NUM_DSP-1:0]   opmode,
  output logic [NUM_DSP-1:0]                cea2,
  output logic [NUM_DSP-1:0]                ceb2,
  output logic [NUM_DSP-1:0]                usemult
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state;
  logic [7:0]           cnt;
  logic [1:0]           sel_q;
  logic [1:0]           op_q;
  logic [NUM_DSP-1:0]   mask_q;
  logic [DELAY-2:0]     vsr;

  logic [1:0]           in_sel;
  logic [1:0]           in_op;
  logic [7:0]           in_rpt;
  logic [NUM_DSP-1:0]   in_mask;
  logic                 accept;
  logic                 issue_v;
  logic                 unused_inst;

  logic [ALUMODE_WIDTH*NUM_DSP-1:0] dec_alumode;
  logic [INMODE_WIDTH*NUM_DSP-1:0]  dec_inmode;
  logic [OPMODE_WIDTH*NUM_DSP-1:0]  dec_opmode;
  logic [NUM_DSP-1:0]               dec_cea2;
  logic [NUM_DSP-1:0]               dec_ceb2;
  logic [NUM_DSP-1:0]               dec_usemult;

  // Opcode bit 2 only marks the immediate variant, which configures the DSP identically.
  assign in_sel      = inst[INST_WIDTH-1 -: 2];
  assign in_op       = inst[25:24];
  assign in_rpt      = inst[23:16];
  assign in_mask     = inst[32 +: NUM_DSP];
  assign unused_inst = ^{inst[INST_WIDTH-3:32+NUM_DSP], inst[31:26], inst[15:0]};

  assign inst_ready = (state == IDLE) || (cnt == 8'd0);
  assign busy       = (state == ISSUE);
  assign accept     = inst_v && inst_ready;
  assign issue_v    = (state == ISSUE) && (op_q != 2'b00) && (|mask_q);

  function automatic logic [DATA_WIDTH*2-1:0] pick(input logic [1:0] s,
                                                   input logic [DATA_WIDTH*2-1:0] ld,
                                                   input logic [DATA_WIDTH*2-1:0] pe,
                                                   input logic [DATA_WIDTH*2-1:0] wb);
    case (s)
      2'b00:   return ld;
      2'b01:   return pe;
      2'b10:   return wb;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    dec_alumode = '0;
    dec_inmode  = '0;
    dec_opmode  = '0;
    dec_cea2    = '0;
    dec_ceb2    = '0;
    dec_usemult = '0;
    for (int i = 0; i < NUM_DSP; i++) begin
      if (in_mask[i]) begin
        case (in_op)
          2'b01: begin
            dec_opmode[i*OPMODE_WIDTH +: OPMODE_WIDTH] = OPMODE_WIDTH'(7'b0110011);
            dec_cea2[i] = 1'b1;
            dec_ceb2[i] = 1'b1;
          end
          2'b10: begin
            dec_alumode[i*ALUMODE_WIDTH +: ALUMODE_WIDTH] = ALUMODE_WIDTH'(4'b0011);
            dec_opmode[i*OPMODE_WIDTH +: OPMODE_WIDTH]    = OPMODE_WIDTH'(7'b0110011);
            dec_cea2[i] = 1'b1;
            dec_ceb2[i] = 1'b1;
          end
          2'b11: begin
            dec_inmode[i*INMODE_WIDTH +: INMODE_WIDTH] = INMODE_WIDTH'(5'b10001);
            dec_opmode[i*OPMODE_WIDTH +: OPMODE_WIDTH] = OPMODE_WIDTH'(7'b0000101);
            dec_usemult[i] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      sel_q   <= 2'b00;
      op_q    <= 2'b00;
      mask_q  <= '0;
      vsr     <= '0;
      dout_v  <= 1'b0;
      dout    <= '0;
      alumode <= '0;
      inmode  <= '0;
      opmode  <= '0;
      cea2    <= '0;
      ceb2    <= '0;
      usemult <= '0;
    end else begin
      if (accept)
        dout <= pick(in_sel, din_ld, din_pe, din_wb);
      else if (state == ISSUE)
        dout <= pick(sel_q, din_ld, din_pe, din_wb);
      else
        dout <= din_pe;

      vsr[0] <= issue_v;
      for (int i = 1; i < DELAY - 1; i++) vsr[i] <= vsr[i-1];
      dout_v <= vsr[DELAY-2];

      if (accept) begin
        state   <= ISSUE;
        cnt     <= in_rpt;
        sel_q   <= in_sel;
        op_q    <= in_op;
        mask_q  <= in_mask;
        alumode <= dec_alumode;
        inmode  <= dec_inmode;
        opmode  <= dec_opmode;
        cea2    <= dec_cea2;
        ceb2    <= dec_ceb2;
        usemult <= dec_usemult;
      end else if (state == ISSUE) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          // Dropping back to IDLE parks every lane in the LOAD configuration.
          state   <= IDLE;
          op_q    <= 2'b00;
          mask_q  <= '0;
          alumode <= '0;
          inmode  <= '0;
          opmode  <= '0;
          cea2    <= '0;
          ceb2    <= '0;
          usemult <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_control_seq.sv
// Directed bench for pe_control_seq: a default 4-lane/DELAY=5 instance and an
// 8-lane/DELAY=3 instance share the same stimulus.
module tb_pe_control_seq;

  localparam int DELAY  = 5;
  localparam int DELAY8 = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] din_ld, din_pe, din_wb;
  logic        inst_v;
  logic [63:0] inst;

  logic        inst_ready, busy, dout_v;
  logic [31:0] dout;
  logic [15:0] alumode;
  logic [19:0] inmode;
  logic [27:0] opmode;
  logic [3:0]  cea2, ceb2, usemult;

  logic        inst_ready8, busy8, dout_v8;
  logic [31:0] dout8;
  logic [31:0] alumode8;
  logic [39:0] inmode8;
  logic [55:0] opmode8;
  logic [7:0]  cea2_8, ceb2_8, usemult8;

  logic [75:0]  cfg4;
  logic [151:0] cfg8;

  int total = 0;
  int bad   = 0;

  localparam logic [75:0] ADD4 = {16'h0, 20'h0, {4{7'b0110011}}, 4'hF, 4'hF, 4'h0};
  localparam logic [75:0] SUB4 = {{4{4'b0011}}, 20'h0, {4{7'b0110011}}, 4'hF, 4'hF, 4'h0};
  localparam logic [75:0] MUL4 = {16'h0, {4{5'b10001}}, {4{7'b0000101}}, 4'h0, 4'h0, 4'hF};
  localparam logic [75:0] MULI_0101 = {16'h0, {5'h0, 5'b10001, 5'h0, 5'b10001},
                                       {7'h0, 7'b0000101, 7'h0, 7'b0000101},
                                       4'h0, 4'h0, 4'b0101};
  localparam logic [151:0] ADD8 = {32'h0, 40'h0, {8{7'b0110011}}, 8'hFF, 8'hFF, 8'h0};

  assign cfg4 = {alumode, inmode, opmode, cea2, ceb2, usemult};
  assign cfg8 = {alumode8, inmode8, opmode8, cea2_8, ceb2_8, usemult8};

  pe_control_seq dut (
    .clk(clk), .rst_n(rst_n), .din_ld(din_ld), .din_pe(din_pe), .din_wb(din_wb),
    .inst_v(inst_v), .inst(inst), .inst_ready(inst_ready), .busy(busy),
    .dout_v(dout_v), .dout(dout), .alumode(alumode), .inmode(inmode),
    .opmode(opmode), .cea2(cea2), .ceb2(ceb2), .usemult(usemult)
  );

  pe_control_seq #(.NUM_DSP(8), .DELAY(DELAY8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din_ld(din_ld), .din_pe(din_pe), .din_wb(din_wb),
    .inst_v(inst_v), .inst(inst), .inst_ready(inst_ready8), .busy(busy8),
    .dout_v(dout_v8), .dout(dout8), .alumode(alumode8), .inmode(inmode8),
    .opmode(opmode8), .cea2(cea2_8), .ceb2(ceb2_8), .usemult(usemult8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [1:0] s, input logic [15:0] m,
                                     input logic [2:0] op, input logic [7:0] r);
    logic [63:0] v;
    v = '0;
    v[63:62] = s;
    v[47:32] = m;
    v[26:24] = op;
    v[23:16] = r;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    inst_v = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    inst_v = 1'b1;
    inst   = mk(2'b01, 16'h000F, 3'b001, 8'd0);
    repeat (3) step();
    total++; if (cfg4 !== 76'h0) begin bad++; $display("[TB] FAIL reset_cfg got=%h exp=0", cfg4); end
    total++; if (dout_v !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout_v got=%b exp=0", dout_v); end
    total++; if (inst_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", inst_ready); end
    total++; if (busy !== 1'b0 || dout !== 32'h0) begin bad++; $display("[TB] FAIL reset_busy_dout got=%b/%h exp=0/0", busy, dout); end
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b1 || cfg4 !== ADD4) begin bad++; $display("[TB] FAIL reset_first_accept got=%b/%h exp=1/%h", busy, cfg4, ADD4); end
    idle(10);
  endtask

  task automatic test_single_add();
    din_pe = 32'h1234_5678;
    inst   = mk(2'b01, 16'h000F, 3'b001, 8'd0);
    inst_v = 1'b1;
    total++; if (inst_ready !== 1'b1) begin bad++; $display("[TB] FAIL add_ready got=%b exp=1", inst_ready); end
    step();
    inst_v = 1'b0;
    total++; if (cfg4 !== ADD4) begin bad++; $display("[TB] FAIL add_cfg got=%h exp=%h", cfg4, ADD4); end
    total++; if (dout !== 32'h1234_5678) begin bad++; $display("[TB] FAIL add_dout got=%h exp=12345678", dout); end
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) begin
        total++; if (cfg4 !== 76'h0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL add_cfg_end got=%h/%b exp=0/0", cfg4, busy); end
      end
      total++; if (dout_v !== (k == DELAY)) begin bad++; $display("[TB] FAIL add_dout_v k=%0d got=%b exp=%b", k, dout_v, k == DELAY); end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [75:0] exp_cfg;
    logic        exp_rdy;
    din_wb = 32'hDEAD_BEEF;
    inst   = mk(2'b10, 16'h000F, 3'b011, 8'd3);
    inst_v = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      exp_cfg = (k <= 3) ? MUL4 : (k == 4) ? SUB4 : 76'h0;
      exp_rdy = (k >= 3);
      total++; if (cfg4 !== exp_cfg) begin bad++; $display("[TB] FAIL b2b_cfg k=%0d got=%h exp=%h", k, cfg4, exp_cfg); end
      total++; if (inst_ready !== exp_rdy) begin bad++; $display("[TB] FAIL b2b_ready k=%0d got=%b exp=%b", k, inst_ready, exp_rdy); end
      total++; if (dout_v !== (k >= 5 && k <= 9)) begin bad++; $display("[TB] FAIL b2b_dout_v k=%0d got=%b exp=%b", k, dout_v, k >= 5 && k <= 9); end
      if (k == 0) begin
        total++; if (dout !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL b2b_dout got=%h exp=deadbeef", dout); end
        inst = mk(2'b01, 16'h000F, 3'b010, 8'd0);
      end
      if (k == 4) inst_v = 1'b0;
    end
    idle(4);
  endtask

  task automatic test_lane_mask();
    inst   = mk(2'b01, 16'h0005, 3'b111, 8'd0);
    inst_v = 1'b1;
    step();
    inst_v = 1'b0;
    total++; if (cfg4 !== MULI_0101) begin bad++; $display("[TB] FAIL mask_cfg got=%h exp=%h", cfg4, MULI_0101); end
    total++; if (usemult !== 4'b0101) begin bad++; $display("[TB] FAIL mask_usemult got=%b exp=0101", usemult); end
    idle(8);
  endtask

  task automatic test_load_and_mask0();
    int ones;
    din_ld = 32'hCAFE_F00D;
    din_pe = 32'hA5A5_0001;
    inst   = mk(2'b00, 16'h000F, 3'b000, 8'd0);
    inst_v = 1'b1;
    step();
    inst_v = 1'b0;
    total++; if (dout !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL load_dout got=%h exp=cafef00d", dout); end
    total++; if (cfg4 !== 76'h0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL load_cfg got=%h/%b exp=0/1", cfg4, busy); end
    ones = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      ones += int'(dout_v);
      if (k == 2) begin
        total++; if (dout !== 32'hA5A5_0001) begin bad++; $display("[TB] FAIL idle_dout got=%h exp=a5a50001", dout); end
      end
    end
    total++; if (ones != 0) begin bad++; $display("[TB] FAIL load_dout_v got=%0d pulses exp=0", ones); end

    inst   = mk(2'b01, 16'h0000, 3'b001, 8'd0);
    inst_v = 1'b1;
    step();
    inst_v = 1'b0;
    total++; if (cfg4 !== 76'h0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL mask0_cfg got=%h/%b exp=0/1", cfg4, busy); end
    ones = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      ones += int'(dout_v) + int'(dout_v8);
    end
    total++; if (ones != 0) begin bad++; $display("[TB] FAIL mask0_dout_v got=%0d pulses exp=0", ones); end
  endtask

  task automatic test_reset_mid_op();
    int ones;
    inst   = mk(2'b01, 16'h00FF, 3'b001, 8'd7);
    inst_v = 1'b1;
    step();
    inst_v = 1'b0;
    step();
    total++; if (busy !== 1'b1 || cfg4 !== ADD4) begin bad++; $display("[TB] FAIL midrst_pre got=%b/%h exp=1/%h", busy, cfg4, ADD4); end
    rst_n = 1'b0;
    #1;
    total++; if (cfg4 !== 76'h0 || cfg8 !== 152'h0) begin bad++; $display("[TB] FAIL midrst_cfg got=%h/%h exp=0/0", cfg4, cfg8); end
    total++; if (busy !== 1'b0 || busy8 !== 1'b0 || inst_ready !== 1'b1 || dout !== 32'h0) begin
      bad++; $display("[TB] FAIL midrst_state got busy=%b busy8=%b rdy=%b dout=%h exp 0/0/1/0", busy, busy8, inst_ready, dout);
    end
    repeat (2) step();
    rst_n = 1'b1;
    ones = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      ones += int'(dout_v) + int'(dout_v8);
    end
    total++; if (ones != 0) begin bad++; $display("[TB] FAIL midrst_dout_v got=%0d pulses exp=0", ones); end
  endtask

  task automatic test_scaled();
    din_wb = 32'h0BAD_CAFE;
    inst   = mk(2'b10, 16'h00FF, 3'b101, 8'd0);
    inst_v = 1'b1;
    step();
    inst_v = 1'b0;
    total++; if (cfg8 !== ADD8) begin bad++; $display("[TB] FAIL scaled_cfg8 got=%h exp=%h", cfg8, ADD8); end
    total++; if (cfg4 !== ADD4) begin bad++; $display("[TB] FAIL scaled_cfg4 got=%h exp=%h", cfg4, ADD4); end
    total++; if (dout8 !== 32'h0BAD_CAFE) begin bad++; $display("[TB] FAIL scaled_dout8 got=%h exp=0badcafe", dout8); end
    for (int k = 1; k <= 7; k++) begin
      step();
      total++; if (dout_v8 !== (k == DELAY8)) begin bad++; $display("[TB] FAIL scaled_dout_v8 k=%0d got=%b exp=%b", k, dout_v8, k == DELAY8); end
      total++; if (dout_v !== (k == DELAY)) begin bad++; $display("[TB] FAIL scaled_dout_v4 k=%0d got=%b exp=%b", k, dout_v, k == DELAY); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    inst_v = 1'b0;
    inst   = '0;
    din_ld = '0;
    din_pe = '0;
    din_wb = '0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_lane_mask();
    test_load_and_mask0();
    test_reset_mid_op();
    test_scaled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_control_seq.md
Name: pe_control_seq

Overview:
- Parametrised next-generation PE control unit.
- Accepts 64-bit PE instructions over a valid/ready handshake and decodes the opcode into per-lane DSP48 configuration (alumode/inmode/opmode/cea2/ceb2/usemult) for NUM_DSP lanes, with a per-lane enable mask.
- Each instruction can be repeated for a programmable number of cycles.
- Sits between the instruction stream and the PE's DSP slice array. Drives the 4-way PE data-output mux and a parametrised-latency output-valid.

Parameters:
- DATA_WIDTH, 16, half-width of data words; data ports are DATA_WIDTH*2 bits.
- INST_WIDTH, 64, instruction width.
- NUM_DSP, 4, number of DSP lanes configured; legal range 1..16.
- ALUMODE_WIDTH, 4, per-lane alumode width.
- INMODE_WIDTH, 5, per-lane inmode width.
- OPMODE_WIDTH, 7, per-lane opmode width.
- DELAY, 5, DSP pipeline depth from issue to dout_v; legal range 2..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din_ld  in  DATA_WIDTH*2  load data.
- din_pe  in  DATA_WIDTH*2  shift data from neighbour PE.
- din_wb  in  DATA_WIDTH*2  write-back data.
- inst_v  in  1  instruction valid.
- inst  in  INST_WIDTH  instruction.
- inst_ready  out  1  block can accept an instruction this cycle.
- busy  out  1  instruction being issued.
- dout_v  out  1  output valid, delayed DELAY cycles from issue.
- dout  out  DATA_WIDTH*2  selected data, registered.
- alumode  out  ALUMODE_WIDTH*NUM_DSP  lane i at [i*W +: W].
- inmode  out  INMODE_WIDTH*NUM_DSP  per-lane inmode.
- opmode  out  OPMODE_WIDTH*NUM_DSP  per-lane opmode.
- cea2  out  NUM_DSP  per-lane CEA2.
- ceb2  out  NUM_DSP  per-lane CEB2.
- usemult  out  NUM_DSP  per-lane USE_MULT.

Behaviour:
- Reset: rst_n low clears everything asynchronously.
  - All outputs go to 0, except inst_ready = 1.
  - FSM goes to IDLE; repeat counter and valid shift register clear.
  - Reset mid-issue aborts the instruction. No dout_v pulses emerge after release for ops issued before reset.
- Instruction fields:
  - sel = inst[INST_WIDTH-1 -: 2]
  - opcode = inst[26:24]
  - rpt = inst[23:16], giving rpt+1 issue cycles
  - lane_mask = inst[32 +: NUM_DSP]
- Handshake:
  - Accept occurs on a rising edge with inst_v & inst_ready.
  - inst_ready = (state==IDLE) | (state==ISSUE & cnt==0), so back-to-back instructions issue with zero bubbles.
  - inst is ignored when inst_v=0 or inst_ready=0.
- FSM (2 states):
  - IDLE:
    - On accept: register decoded config, cnt<=rpt, latch sel/opcode/mask, go to ISSUE.
    - Otherwise hold.
  - ISSUE:
    - If cnt!=0: cnt<=cnt-1 and config is held.
    - If cnt==0 with an accept: reload from the new instruction and stay in ISSUE.
    - If cnt==0 without an accept: config outputs <= 0 (LOAD), go to IDLE.
  - busy = (state==ISSUE).
- Latency and config window:
  - Config outputs change on the accept edge.
  - They are stable for exactly rpt+1 cycles.
- Decode, applied identically to each lane whose mask bit is 1:
  - 001 ADD / 101 ADDI: alumode 0000, inmode 00000, opmode 0110011, cea2 1, ceb2 1, usemult 0.
  - 010 SUB / 110 SUBI: alumode 0011, inmode 00000, opmode 0110011, cea2 1, ceb2 1, usemult 0.
  - 011 MUL / 111 MULI: alumode 0000, inmode 10001, opmode 0000101, cea2 0, ceb2 0, usemult 1.
  - 000, 100 (LOAD): all fields 0.
  - Masked-off lanes (mask bit 0) get all-zero fields regardless of opcode.
- dout: registered every cycle.
  - In ISSUE, select by the latched sel: 00 din_ld, 01 din_pe, 10 din_wb, 11 zero.
  - In IDLE: dout <= din_pe (shift default).
  - On the accept edge, the mux uses the incoming sel.
- Valid path:
  - issue_v = 1 on each cycle whose registered config is a non-LOAD opcode with at least one mask bit set.
  - issue_v feeds a DELAY-1 stage shift register.
  - dout_v rises exactly DELAY cycles after the accept edge and stays high for rpt+1 cycles.
  - LOAD or mask=0 produce no dout_v.
- Widths: cnt is 8 bits and never wraps, because the decrement is blocked at 0.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with inst_v=1 -> all config outputs 0, dout_v=0, inst_ready=1; first accept occurs on the first edge after release.
- Single ADD: opcode 001, rpt=0, mask=4'b1111, sel=01, din_pe=32'h1234_5678 ->
  - opmode=28'b0110011 repeated 4x for 1 cycle, cea2=ceb2=4'b1111;
  - dout=32'h1234_5678;
  - dout_v single pulse exactly DELAY=5 cycles after accept.
- Repeat plus back-to-back: MUL rpt=3, then SUB rpt=0 presented continuously ->
  - MUL config (inmode 10001 per lane, usemult 4'b1111) held 4 cycles, then SUB (alumode 0011 per lane) 1 cycle;
  - inst_ready low for 3 cycles;
  - dout_v high for 5 consecutive cycles.
- Lane mask: MULI with mask=4'b0101 -> usemult=4'b0101; lanes 1 and 3 have inmode/opmode 0.
- LOAD and mask 0: LOAD with sel=00, din_ld=32'hCAFE_F00D -> dout=32'hCAFE_F00D, dout_v stays 0. ADD with mask=0 -> dout_v stays 0.
- Reset mid-op: assert rst_n=0 in the 2nd cycle of an ADD with rpt=7 -> outputs clear immediately and no dout_v appears afterwards; rerun with NUM_DSP=8, DELAY=3 to confirm scaled widths and latency.
